// File: rtl/circ_shift_reg_param.sv
// circ_shift_reg_param: parametrised circular shift register / pattern clock divider.
// The low `length` bits rotate once per enabled clock; bits above the active loop hold.
// A registered `wrap` pulse marks each completed rotation period.
// Optional feature macro: DIR_EN. When it is defined, `dir` selects rotate left (1) or
// right (0). When it is undefined, `dir` is ignored and the rotation is always right.
module circ_shift_reg_param #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_in,
    input  logic             enable,
    input  logic             dir,
    input  logic [LW-1:0]    length,
    output logic [WIDTH-1:0] q,
    output logic             shift_out,
    output logic             wrap
);

    // Index of the top bit of the active loop (L-1); length 0 encodes L = WIDTH.
    logic [LW-1:0]    len_last;
    logic             rot_left;
    logic [WIDTH-1:0] q_rot;
    logic [WIDTH:0]   q_ext;
    logic [LW-1:0]    pos_q, pos_d;
    logic             wrap_d;

    assign len_last = (length == '0) ? LW'(WIDTH - 1) : length - LW'(1);

`ifdef DIR_EN
    assign rot_left = dir;
`else
    // Port kept so the interface is identical in both builds.
    logic unused_dir;
    assign unused_dir = dir;
    assign rot_left   = 1'b0;
`endif

    // Zero-extended copy so the right-rotate loop can read bit i+1 for every i.
    assign q_ext = {1'b0, q};

    // Rotate only bits [L-1:0] by one place; bits at and above L pass through unchanged.
    always_comb begin
        q_rot = q;
        if (rot_left) begin
            q_rot[0] = q[len_last];
            for (int i = 1; i < int'(WIDTH); i++) begin
                if (i <= int'(len_last)) begin
                    q_rot[i] = q[i-1];
                end
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (i < int'(len_last)) begin
                    q_rot[i] = q_ext[i+1];
                end
            end
            q_rot[len_last] = q[0];
        end
    end

    // Period counter next state; >= so a shortened length wraps on the very next shift.
    always_comb begin
        pos_d  = pos_q + LW'(1);
        wrap_d = 1'b0;
        if (pos_q >= len_last) begin
            pos_d  = '0;
            wrap_d = 1'b1;
        end
    end

    // State update with priority reset > load > shift > hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q     <= '0;
            pos_q <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            q     <= load_in;
            pos_q <= '0;
            wrap  <= 1'b0;
        end else if (enable) begin
            q     <= q_rot;
            pos_q <= pos_d;
            wrap  <= wrap_d;
        end else begin
            wrap  <= 1'b0;
        end
    end

    assign shift_out = q[0];

endmodule

// File: tb/tb_circ_shift_reg_param.sv
// Self-checking bench for circ_shift_reg_param (WIDTH = 16).
// A shift-count model runs alongside the DUT and is compared every cycle;
// directed sequences add hand-computed literal expectations.
module tb_circ_shift_reg_param;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_in = '0;
    logic        enable = 1'b0;
    logic        dir = 1'b0;
    logic [3:0]  length = '0;
    logic [15:0] q;
    logic        shift_out;
    logic        wrap;

    int vectors = 0;
    int miscompares = 0;
    bit run = 1'b0;

    circ_shift_reg_param #(.WIDTH(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .load_in   (load_in),
        .enable    (enable),
        .dir       (dir),
        .length    (length),
        .q         (q),
        .shift_out (shift_out),
        .wrap      (wrap)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Rotate the low l bits of v by one place using mask arithmetic.
    function automatic logic [15:0] model_rot(input logic [15:0] v, input int l, input bit left);
        logic [31:0] mask, seg, r;
        mask = (32'h1 << l) - 32'h1;
        seg  = {16'h0, v} & mask;
        if (left) r = ((seg << 1) & mask) | (seg >> (l - 1));
        else      r = (seg >> 1) | ((seg & 32'h1) << (l - 1));
        return r[15:0] | (v & ~mask[15:0]);
    endfunction

    // Model: pattern plus number of shifts since last load or wrap.
    logic [15:0] m_q;
    int          m_cnt;
    logic        m_wrap;

    always @(posedge clock or posedge reset) begin
        int  l;
        bit  left;
        if (reset) begin
            m_q = '0; m_cnt = 0; m_wrap = 1'b0;
        end else if (load) begin
            m_q = load_in; m_cnt = 0; m_wrap = 1'b0;
        end else if (enable) begin
            l = (length == 4'd0) ? 16 : int'(length);
`ifdef DIR_EN
            left = dir;
`else
            left = 1'b0;
`endif
            m_q   = model_rot(m_q, l, left);
            m_cnt = m_cnt + 1;
            if (m_cnt >= l) begin
                m_cnt = 0; m_wrap = 1'b1;
            end else begin
                m_wrap = 1'b0;
            end
        end else begin
            m_wrap = 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (run) begin
            check("model_q", 64'(q), 64'(m_q));
            check("model_shift_out", 64'(shift_out), 64'(m_q[0]));
            check("model_wrap", 64'(wrap), 64'(m_wrap));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Shift until wrap is seen; returns the number of shifts (41 means it never came).
    task automatic shifts_to_wrap(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!wrap && n <= 40);
    endtask

    task automatic do_load(input logic [15:0] v, input logic en);
        load = 1'b1; load_in = v; enable = en;
        tick();
        load = 1'b0;
    endtask

    initial begin
        int          n;
        logic [7:0]  so8;
        logic [8:0]  wr9;
        logic [15:0] nib;
        logic [15:0] held;

        #12;
        reset = 1'b0;
        #2;
        run = 1'b1;
        check("reset_q", 64'(q), 64'h0);
        check("reset_shift_out", 64'(shift_out), 64'h0);
        check("reset_wrap", 64'(wrap), 64'h0);

        // 1: clock/4 pattern over full width.
        length = 4'd0; dir = 1'b0;
        do_load(16'hCCCC, 1'b1);
        so8[0] = shift_out;
        for (int k = 1; k < 8; k++) begin
            tick();
            so8[k] = shift_out;
        end
        check("div4_shift_out", 64'(so8), 64'h00CC);
        shifts_to_wrap(n);
        check("div4_wrap_period", 64'(n + 7), 64'd16);
        check("div4_q_at_wrap", 64'(q), 64'hCCCC);
        shifts_to_wrap(n);
        check("div4_second_wrap", 64'(n), 64'd16);

        // 2: length 3 loop.
        length = 4'd3;
        do_load(16'h0001, 1'b1);
        so8[0] = shift_out;
        wr9 = '0;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (k < 5) so8[k+1] = shift_out;
            wr9[k] = wrap;
            if (q[15:3] != 13'h0) check("len3_upper_zero", 64'(q), 64'(q & 16'h0007));
        end
        check("len3_shift_out", 64'(so8[5:0]), 64'h09);
        check("len3_wrap_pattern", 64'(wr9), 64'h124);
        check("len3_upper_final", 64'(q[15:3]), 64'h0);

        // 3: direction with length 4.
        length = 4'd4; dir = 1'b1;
        do_load(16'h0001, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            nib[15 - 4*k -: 4] = q[3:0];
        end
`ifdef DIR_EN
        check("len4_dir_left_seq", 64'(nib), 64'h2481);
`else
        check("len4_dir_ignored_seq", 64'(nib), 64'h8421);
`endif
        check("len4_wrap_on_return", 64'(wrap), 64'h1);
        dir = 1'b0;

        // 4: load beats enable.
        length = 4'd0;
        do_load(16'hAAAA, 1'b0);
        tick();
        check("hold_aaaa", 64'(q), 64'hAAAA);
        do_load(16'h0F0F, 1'b1);
        check("load_priority_q", 64'(q), 64'h0F0F);
        check("load_priority_wrap", 64'(wrap), 64'h0);
        shifts_to_wrap(n);
        check("load_priority_pos0", 64'(n), 64'd16);

        // 5: hold for 5 cycles after 2 shifts.
        do_load(16'hCCCC, 1'b1);
        tick();
        tick();
        enable = 1'b0;
        held = q;
        check("two_shifts_q", 64'(held), 64'h3333);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (q !== 16'h3333 || wrap !== 1'b0)
                check("hold_frozen", 64'({wrap, q}), 64'h3333);
        end
        check("hold_end_q", 64'(q), 64'h3333);
        enable = 1'b1;
        shifts_to_wrap(n);
        check("resume_wrap_after", 64'(n), 64'd14);

        // Length shortened mid-rotation wraps on the next shift.
        do_load(16'h0001, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        length = 4'd3;
        tick();
        check("len_change_q", 64'(q), 64'h0800);
        check("len_change_wrap", 64'(wrap), 64'h1);
        length = 4'd0;

        // 6: asynchronous reset mid-cycle.
        do_load(16'hCCCC, 1'b1);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_q", 64'(q), 64'h0);
        check("async_reset_shift_out", 64'(shift_out), 64'h0);
        check("async_reset_wrap", 64'(wrap), 64'h0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        check("post_reset_q", 64'(q), 64'h0);
        check("post_reset_wrap_free", 64'(wrap), 64'h0);
        do_load(16'h8001, 1'b0);
        check("reload_after_reset", 64'(q), 64'h8001);

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case a sequence stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
